// File: rtl/memory_master_pkg.sv
// memory_master_pkg: shared definitions for the memory_master CPU-to-RAM
// bridge. Holds the CPU op codes, the controller state encoding and the
// default RMW write-data timeout.
package memory_master_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_RMW   = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RMW_READ,
    S_RMW_HOLD,
    S_RMW_WRITE,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/memory_master.sv
// memory_master: single-request bridge between a CPU request port and a
// synchronous-write / combinational-read RAM. Supports word/byte READ,
// WRITE and a split read-modify-write whose write phase waits for
// cpu_wvalid for at most TIMEOUT cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_req/cpu_ready   request handshake (accepted only in IDLE)
//   cpu_op, cpu_byte    operation and access width
//   cpu_addr, cpu_wdata byte address, write data (bytes use [7:0])
//   cpu_wvalid          RMW write-phase data valid
//   cpu_done, cpu_err   one-cycle completion pulse and its error qualifier
//   cpu_rdata           captured read data, held until the next capture
//   mem_addr, mem_we, mem_bytew, mem_wdata  registered RAM controls
//   mem_rdata           combinational RAM read data
module memory_master
  import memory_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  output logic        cpu_ready,
  input  logic [1:0]  cpu_op,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        cpu_wvalid,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_bytew,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  // Hold-cycle counter covers 0..TIMEOUT-1: RMW_HOLD lasts at most TIMEOUT
  // cycles, and cpu_wvalid on the final hold edge still beats the timeout.
  localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          bad_req;

  assign accept  = (state_q == S_IDLE) && cpu_req;
  assign bad_req = (!cpu_byte && cpu_addr[0]) || (op_e'(cpu_op) == OP_RSVD);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (bad_req) begin
            state_d = S_ERR;
          end else begin
            unique case (op_e'(cpu_op))
              OP_READ:  state_d = S_READ;
              OP_WRITE: state_d = S_WRITE;
              default:  state_d = S_RMW_READ;
            endcase
          end
        end
      end
      S_READ, S_WRITE: state_d = S_DONE;
      S_RMW_READ:      state_d = S_RMW_HOLD;
      S_RMW_HOLD: begin
        if (cpu_wvalid) begin
          state_d = S_RMW_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_RMW_WRITE:     state_d = S_DONE;
      S_DONE, S_ERR:   state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  // Handshake/strobe outputs are registered from the next state so that
  // they line up with the state they describe and clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cpu_ready <= 1'b1;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_bytew <= 1'b0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cpu_ready <= (state_d == S_IDLE);
      // RMW reports its read half as soon as the data is captured.
      cpu_done  <= (state_d == S_DONE) || (state_d == S_ERR) ||
                   (state_q == S_RMW_READ);
      cpu_err   <= (state_d == S_ERR);
      mem_we    <= (state_d == S_WRITE) || (state_d == S_RMW_WRITE);

      if (accept) begin
        mem_addr  <= cpu_addr;
        mem_bytew <= cpu_byte;
        mem_wdata <= cpu_wdata;
      end

      if ((state_q == S_READ) || (state_q == S_RMW_READ)) begin
        cpu_rdata <= mem_bytew ? {8'h00, mem_rdata[7:0]} : mem_rdata;
      end

      if ((state_q == S_RMW_HOLD) && cpu_wvalid) begin
        mem_wdata <= cpu_wdata;
      end

      if (state_q == S_RMW_HOLD) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_master.sv
// tb_memory_master: drives memory_master against a bench RAM and checks
// every cycle against a transaction-level reference (expected handshake,
// strobes, address/data and read result derived from the op sequence).
module tb_memory_master;
  import memory_master_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req, cpu_ready, cpu_byte, cpu_wvalid, cpu_done, cpu_err;
  logic [1:0]  cpu_op;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_bytew;

  always #5 clk = ~clk;

  memory_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_ready(cpu_ready), .cpu_op(cpu_op),
    .cpu_byte(cpu_byte), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wvalid(cpu_wvalid), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_bytew(mem_bytew), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Bench RAM: odd byte address presents its byte in [7:0] (other byte above).
  logic [15:0] ram [0:32767];
  logic [15:0] mdl [0:32767];
  bit          ram_init = 1'b1;
  int          we_cycles = 0;
  logic [14:0] wi;
  assign wi = mem_addr[15:1];
  assign mem_rdata = mem_addr[0] ? {ram[wi][7:0], ram[wi][15:8]} : ram[wi];

  function automatic logic [15:0] fill(int unsigned i);
    return 16'(i * 40503 + 12345);
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int unsigned i = 0; i < 32768; i++) ram[i] <= fill(i);
    end else if (mem_we) begin
      we_cycles <= we_cycles + 1;
      if (!mem_bytew)     ram[wi]       <= mem_wdata;
      else if (mem_addr[0]) ram[wi][15:8] <= mem_wdata[7:0];
      else                ram[wi][7:0]  <= mem_wdata[7:0];
    end
  end

  // Reference model state and the expectations for the current cycle.
  int          n_checks = 0, n_err = 0;
  bit          chk_en = 1'b0;
  bit          e_rdy, e_dn, e_er, e_we, e_bw;
  logic [15:0] e_addr, e_wd, e_rd;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mrd(input logic [15:0] a, input bit b);
    logic [15:0] w;
    w = mdl[a[15:1]];
    if (!b) return w;
    return a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  task automatic mwr(input logic [15:0] a, input bit b, input logic [15:0] d);
    if (!b)        mdl[a[15:1]]       = d;
    else if (a[0]) mdl[a[15:1]][15:8] = d[7:0];
    else           mdl[a[15:1]][7:0]  = d[7:0];
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 16'(cpu_ready), 16'(e_rdy));
      chk("done",  16'(cpu_done),  16'(e_dn));
      chk("err",   16'(cpu_err),   16'(e_er));
      chk("we",    16'(mem_we),    16'(e_we));
      chk("addr",  mem_addr,       e_addr);
      chk("bytew", 16'(mem_bytew), 16'(e_bw));
      chk("rdata", cpu_rdata,      e_rd);
      if (e_we) chk("wdata", mem_wdata, e_wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setexp(input bit r, input bit d, input bit e, input bit w);
    e_rdy = r; e_dn = d; e_er = e; e_we = w;
  endtask

  // Random values on every input; outside IDLE they must all be ignored.
  task automatic garbage();
    cpu_req    = 1'($urandom);
    cpu_op     = 2'($urandom);
    cpu_byte   = 1'($urandom);
    cpu_addr   = 16'($urandom);
    cpu_wdata  = 16'($urandom);
    cpu_wvalid = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      garbage();
      cpu_req = 1'b0;
    end
  endtask

  // Called in an IDLE cycle; returns in the IDLE cycle after completion.
  // For RMW, wd is the write-phase data and hw the hold cycle carrying
  // cpu_wvalid (0 = never, forcing the timeout).
  task automatic do_txn(input logic [1:0] op, input bit byt, input logic [15:0] addr,
                        input logic [15:0] wd, input int unsigned hw);
    bit fired;
    garbage();
    cpu_req = 1'b1; cpu_op = op; cpu_byte = byt; cpu_addr = addr;
    cpu_wdata = (op == 2'b10) ? 16'($urandom) : wd;
    tick();
    e_addr = addr; e_bw = byt;
    if ((!byt && addr[0]) || op == 2'b11) begin
      setexp(0, 1, 1, 0);
    end else begin
      setexp(0, 0, 0, op == 2'b01);
      e_wd = wd;
      garbage();
      tick();
      if (op == 2'b00) begin
        e_rd = mrd(addr, byt);
        setexp(0, 1, 0, 0);
      end else if (op == 2'b01) begin
        mwr(addr, byt, wd);
        setexp(0, 1, 0, 0);
        chk("ram_wr", ram[addr[15:1]], mdl[addr[15:1]]);
      end else begin
        e_rd = mrd(addr, byt);
        setexp(0, 1, 0, 0);
        fired = 1'b0;
        for (int unsigned j = 1; j <= TO; j++) begin
          garbage();
          cpu_wvalid = (j == hw);
          if (j == hw) cpu_wdata = wd;
          tick();
          if (j == hw) begin
            setexp(0, 0, 0, 1);
            e_wd = wd;
            garbage();
            tick();
            mwr(addr, byt, wd);
            setexp(0, 1, 0, 0);
            chk("ram_rmw", ram[addr[15:1]], mdl[addr[15:1]]);
            fired = 1'b1;
            break;
          end else if (j == TO) begin
            setexp(0, 1, 1, 0);
          end else begin
            setexp(0, 0, 0, 0);
          end
        end
        if (!fired) chk("ram_to", ram[addr[15:1]], mdl[addr[15:1]]);
      end
    end
    garbage();
    tick();
    setexp(1, 0, 0, 0);
    garbage();
    cpu_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          we0;
    int unsigned r;
    logic [1:0]  op;
    bit          b;
    logic [15:0] a;

    for (int unsigned i = 0; i < 32768; i++) mdl[i] = fill(i);
    cpu_req = 0; cpu_op = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wvalid = 0;
    setexp(1, 0, 0, 0);
    e_addr = '0; e_bw = 1'b0; e_rd = '0; e_wd = '0;
    chk_en = 1'b1;
    tick();
    ram_init = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Word write then read back.
    do_txn(2'b01, 0, 16'h1000, 16'hA5C3, 0);
    do_txn(2'b00, 0, 16'h1000, 16'h0000, 0);
    chk("lit_rd_word", cpu_rdata, 16'hA5C3);
    // Byte read of the high byte, byte write of the high byte.
    do_txn(2'b00, 1, 16'h1001, 16'h0000, 0);
    chk("lit_rd_byte", cpu_rdata, 16'h00A5);
    do_txn(2'b01, 1, 16'h1001, 16'h5577, 0);
    chk("lit_ram_byte", ram[16'h1000 >> 1], 16'h77C3);
    // Misaligned word access and reserved op: no RAM access at all.
    we0 = we_cycles;
    do_txn(2'b00, 0, 16'h1003, 16'h0000, 0);
    do_txn(2'b11, 0, 16'h1002, 16'h9999, 0);
    chk("lit_err_nowe", 16'(we_cycles - we0), 16'h0000);
    // RMW with write data on the last allowed hold edge.
    do_txn(2'b01, 0, 16'h2000, 16'h1234, 0);
    do_txn(2'b10, 0, 16'h2000, 16'h1235, TO);
    chk("lit_rmw_rd", cpu_rdata, 16'h1234);
    chk("lit_rmw_ram", ram[16'h2000 >> 1], 16'h1235);
    // RMW timeout: RAM untouched.
    do_txn(2'b10, 0, 16'h2000, 16'hDEAD, 0);
    chk("lit_to_ram", ram[16'h2000 >> 1], 16'h1235);

    // Reset asserted mid-WRITE.
    do_txn(2'b01, 0, 16'h3000, 16'h0F0F, 0);
    garbage();
    cpu_req = 1'b1; cpu_op = 2'b01; cpu_byte = 1'b0; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF;
    tick();
    e_addr = 16'h3000; e_bw = 1'b0; e_wd = 16'hBEEF;
    setexp(0, 0, 0, 1);
    cpu_req = 1'b0;
    chk("lit_abort_we_on", 16'(mem_we), 16'h0001);
    #2;
    rst_n = 1'b0;
    setexp(1, 0, 0, 0);
    e_addr = '0; e_bw = 1'b0; e_rd = '0;
    #1;
    chk("lit_abort_we_off", 16'(mem_we), 16'h0000);
    chk("lit_abort_ready", 16'(cpu_ready), 16'h0001);
    tick();
    tick();
    rst_n = 1'b1;
    chk("lit_abort_ram", ram[16'h3000 >> 1], 16'h0F0F);
    do_txn(2'b00, 0, 16'h3000, 16'h0000, 0);
    chk("lit_abort_rd", cpu_rdata, 16'h0F0F);

    // Randomized traffic over a small address window.
    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      b  = 1'($urandom);
      a  = {12'h400, 4'($urandom)};
      do_txn(op, b, a, 16'($urandom), $urandom_range(0, TO));
      idle(int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_master.md
MEMORY_MASTER -- requirements
Module: memory_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the max cycles an RMW waits for write data.
REQ-003 clk  in  1  sole clock; all state changes on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cpu_req  in  1  request valid; accepted when cpu_req && cpu_ready at posedge clk.
REQ-006 cpu_ready  out  1  high only in IDLE.
REQ-007 cpu_op  in  2  00 READ, 01 WRITE, 10 RMW, 11 reserved.
REQ-008 cpu_byte  in  1  byte access when 1, word when 0.
REQ-009 cpu_addr  in  16  byte address.
REQ-010 cpu_wdata  in  16  write data; byte writes use bits [7:0].
REQ-011 cpu_wvalid  in  1  RMW write-phase data valid, sampled only in RMW_HOLD.
REQ-012 cpu_done  out  1  one-cycle completion pulse.
REQ-013 cpu_err  out  1  qualifies cpu_done: odd-address, reserved-op or RMW timeout.
REQ-014 cpu_rdata  out  16  read result, valid with cpu_done; holds until next capture.
REQ-015 mem_addr  out  16  registered address to the RAM.
REQ-016 mem_we  out  1  registered write enable to the RAM.
REQ-017 mem_bytew  out  1  registered byte-write qualifier to the RAM.
REQ-018 mem_wdata  out  16  registered data to the RAM data input.
REQ-019 mem_rdata  in  16  combinational read data from the RAM; odd byte address returns addressed byte in [7:0].

Function
REQ-020 States SHALL be IDLE, READ, WRITE, RMW_READ, RMW_HOLD, RMW_WRITE, DONE, ERR.
REQ-021 On accept: addr, op, byte, wdata registered; mem_addr := cpu_addr, mem_bytew := cpu_byte.
REQ-022 Accept with cpu_byte=0 and cpu_addr[0]=1, or cpu_op=11, SHALL go to ERR with no RAM access (mem_we stays 0).
REQ-023 READ: next edge captures mem_rdata into cpu_rdata (byte: zero-extend [7:0]), then DONE.
REQ-024 WRITE: mem_we=1 for exactly one cycle with mem_wdata = registered wdata; next edge -> DONE.
REQ-025 DONE and ERR SHALL last one cycle, asserting cpu_done (ERR also cpu_err), then return to IDLE.
REQ-026 Latency: cpu_done high in the second cycle after the accept edge for READ/WRITE, first cycle for ERR.
REQ-027 RMW_READ: capture as READ, pulse cpu_done (err=0) in the cycle entering RMW_HOLD.
REQ-028 RMW_HOLD: address held, cpu_ready=0; cpu_wvalid at edge loads mem_wdata from cpu_wdata -> RMW_WRITE.
REQ-029 RMW_WRITE: mem_we=1 one cycle at held address/width, then DONE.
REQ-030 RMW_HOLD SHALL count cycles from 0; at count = TIMEOUT without cpu_wvalid -> ERR; cpu_wvalid at that same edge wins.
REQ-031 cpu_req outside IDLE SHALL be ignored; no queuing.
REQ-032 mem_we SHALL never be high outside WRITE and RMW_WRITE.

Reset
REQ-033 rst_n low SHALL immediately force IDLE and all outputs to 0 except cpu_ready=1, including mid-operation; an aborted write SHALL see mem_we drop asynchronously.
REQ-034 Timeout counter and all registers SHALL clear to 0 on reset; first accept possible at first edge after rst_n rises.

Structure
REQ-035 Package memory_master_pkg SHALL hold op codes, state enum and default TIMEOUT.
REQ-036 Single module; no sub-module is required.

Verification
REQ-037 Word WRITE 0x1000 <- 0xA5C3, then READ 0x1000 -> cpu_done 2 cycles after accept, cpu_rdata=0xA5C3, err=0.
REQ-038 Byte READ 0x1001 with RAM word 0xA5C3 -> cpu_rdata=0x00A5; byte WRITE 0x1001 <- 0x77 -> mem_bytew=1, mem_wdata[7:0]=0x77.
REQ-039 Word READ 0x1003 -> cpu_done=cpu_err=1 in next cycle, mem_we never high; cpu_op=11 -> same.
REQ-040 RMW 0x2000 (0x1234): done with rdata=0x1234, wvalid after 5 cycles with 0x1235 -> RAM 0x2000=0x1235.
REQ-041 RMW with no cpu_wvalid, TIMEOUT=4 -> ERR pulse after 4 hold cycles, IDLE, RAM unchanged.
REQ-042 rst_n low during WRITE cycle -> mem_we 0 immediately, RAM unchanged, cpu_ready=1 after release.
